// File: rtl/butterfly_dmem.sv
// butterfly_dmem: word-organised data memory with byte strobes, range check and wait states
module butterfly_dmem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        dmem_valid_i,
    input  logic        dmem_we_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [3:0]  dmem_wstrb_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_ready_o,
    output logic        dmem_err_o
);
    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          accept;
    logic          access;

    // addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare covers both bounds
    assign off      = addr_q - BASE_ADDR;
    assign in_range = off < SPAN;
    assign idx      = off[AW+1:2];
    assign accept   = (state_q == S_IDLE) && dmem_valid_i;
    assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // next-state: IDLE -> WAIT on request, WAIT drains cnt, RESP lasts one cycle
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = dmem_valid_i ? S_WAIT : S_IDLE;
            S_WAIT:  state_d = (cnt_q == 4'd0) ? S_RESP : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // latch request payload in IDLE, count wait states, register the response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            dmem_ready_o <= 1'b0;
            dmem_err_o   <= 1'b0;
            dmem_rdata_o <= 32'd0;
        end else begin
            if (accept) begin
                cnt_q   <= 4'(WAIT_CYCLES);
                we_q    <= dmem_we_i;
                addr_q  <= dmem_addr_i;
                wdata_q <= dmem_wdata_i;
                wstrb_q <= dmem_wstrb_i;
            end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            dmem_ready_o <= access;
            dmem_err_o   <= access && !in_range;
            if (access && !we_q) dmem_rdata_o <= in_range ? mem[idx] : 32'd0;
        end
    end

    // byte-lane writes; storage has no reset so it maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (access && we_q && in_range)
            for (int i = 0; i < 4; i++)
                if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule
